// File: rtl/kda_pkg.sv
// kda_pkg: shared state encoding, job header layout and salt block-index insertion for kda_sched.
package kda_pkg;
    typedef enum logic [1:0] {LOAD, DISPATCH, WAIT, DRAIN} kda_sched_state_e;
    localparam int ITERS_LSB = 32;
    localparam int SLEN_W = 6;
    localparam int SALT_MAX = 1024;
    // salt is left-aligned in SALT_MAX bits; k is written big-endian starting at byte salt_len
    function automatic logic [SALT_MAX-1:0] insert_blk_idx(
        input logic [SALT_MAX-1:0] salt,
        input logic [SLEN_W-1:0]   salt_len,
        input logic [31:0]         k
    );
        logic [SALT_MAX-1:0] m;
        logic [SALT_MAX-1:0] v;
        m = {32'hFFFF_FFFF, {(SALT_MAX-32){1'b0}}} >> {salt_len, 3'b000};
        v = {k, {(SALT_MAX-32){1'b0}}} >> {salt_len, 3'b000};
        return (salt & ~m) | v;
    endfunction
endpackage

// File: rtl/kda_sched_ser.sv
// kda_sched_ser: one hash slot per engine, drained slot 0 first, MS word first, done pulses on the last word.
module kda_sched_ser #(
    parameter int DATA_W = 64, NUM_ENGINES = 4, HASH_W = 256
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [NUM_ENGINES-1:0]               wr_i,
    input  logic [NUM_ENGINES*HASH_W-1:0]        hash_i,
    input  logic                                 start_i,
    input  logic [$clog2(NUM_ENGINES+1)-1:0]     slots_i,
    output logic [DATA_W-1:0]                    data_o,
    output logic                                 v_o,
    input  logic                                 yumi_i,
    output logic                                 done_o
);
    localparam int WPH = HASH_W / DATA_W;
    localparam int SW = $clog2(NUM_ENGINES + 1);
    localparam int WW = $clog2(WPH + 1);
    localparam int BW = $clog2(NUM_ENGINES * HASH_W);

    logic [NUM_ENGINES*HASH_W-1:0] buf_q;
    logic [SW-1:0] slot_q, nslot_q;
    logic [WW-1:0] word_q;
    logic v_q, last_w, last_s;
    logic [BW-1:0] sel;

    assign last_w = word_q == WW'(WPH - 1);
    assign last_s = slot_q == nslot_q - SW'(1);
    assign sel = BW'(int'(slot_q) * HASH_W + (WPH - 1 - int'(word_q)) * DATA_W);
    assign data_o = v_q ? buf_q[sel +: DATA_W] : '0;
    assign v_o = v_q;
    assign done_o = v_q & yumi_i & last_w & last_s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q   <= '0;
            v_q     <= 1'b0;
            slot_q  <= '0;
            nslot_q <= '0;
            word_q  <= '0;
        end else begin
            for (int e = 0; e < NUM_ENGINES; e++)
                if (wr_i[e]) buf_q[e*HASH_W +: HASH_W] <= hash_i[e*HASH_W +: HASH_W];
            if (start_i) begin
                v_q     <= 1'b1;
                slot_q  <= '0;
                word_q  <= '0;
                nslot_q <= slots_i;
            end else if (v_q && yumi_i) begin
                word_q <= last_w ? '0 : word_q + WW'(1);
                if (last_w) begin
                    slot_q <= slot_q + SW'(1);
                    if (last_s) v_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/kda_sched.sv
// kda_sched: loads one PBKDF2 job, fans blocks 1..N out to NUM_ENGINES engines in rounds, streams hashes in block order.
// Defining KDA_SCHED_PERF_EN adds perf_cycles_o, a saturating word0-to-final-yumi cycle counter.
module kda_sched
    import kda_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int NUM_ENGINES = 4,
    parameter int MAX_BLOCKS  = 8,
    parameter int PASS_W      = 512,
    parameter int SALT_W      = 512,
    parameter int HASH_W      = 256
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [DATA_W-1:0]             data_o,
    output logic                          v_o,
    input  logic                          yumi_i,
    output logic [NUM_ENGINES-1:0]        eng_v_o,
    input  logic [NUM_ENGINES-1:0]        eng_ready_i,
    output logic [31:0]                   eng_iters_o,
    output logic [5:0]                    eng_slen_o,
    output logic [PASS_W-1:0]             eng_pass_o,
    output logic [NUM_ENGINES*SALT_W-1:0] eng_salt_o,
    input  logic [NUM_ENGINES-1:0]        eng_v_i,
    input  logic [NUM_ENGINES*HASH_W-1:0] eng_hash_i,
    output logic [NUM_ENGINES-1:0]        eng_yumi_o
`ifdef KDA_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_cycles_o
`endif
);
    localparam int BLK_W = $clog2(MAX_BLOCKS);
    localparam int PW = PASS_W / DATA_W;
    localparam int SW = SALT_W / DATA_W;
    localparam int LW = $clog2(PW + SW + 1);
    localparam int CW = 16;
    localparam int NW = $clog2(NUM_ENGINES + 1);
    localparam logic [LW-1:0] PASS_END = LW'(PW);
    localparam logic [LW-1:0] LOAD_END = LW'(PW + SW);

    kda_sched_state_e state_q;
    logic [LW-1:0] wcnt_q;
    logic [31:0] iters_q;
    logic [SLEN_W-1:0] slen_q;
    logic [CW-1:0] nblk_q, base_q, nblk_d, rem, next_base;
    logic [PASS_W-1:0] pass_q;
    logic [SALT_W-1:0] salt_q;
    logic [NUM_ENGINES-1:0] active, sent_q, sent_d, cap_q, cap_d;
    logic [NW-1:0] slots;
    logic [BLK_W-1:0] nfield;
    logic ser_start, ser_done, last_round;

    assign nfield = data_i[BLK_W-1:0];
    assign nblk_d = (CW'(nfield) >= CW'(MAX_BLOCKS)) ? CW'(MAX_BLOCKS) : CW'(nfield) + CW'(1);
    assign rem = nblk_q - base_q;
    assign next_base = base_q + CW'(NUM_ENGINES);
    assign last_round = next_base >= nblk_q;
    assign slots = (rem >= CW'(NUM_ENGINES)) ? NW'(NUM_ENGINES) : NW'(rem);
    assign ready_o = state_q == LOAD;
    assign eng_v_o = (state_q == DISPATCH) ? active & ~sent_q : '0;
    assign eng_yumi_o = (state_q == WAIT) ? eng_v_i & active & ~cap_q : '0;
    assign sent_d = sent_q | (eng_v_o & eng_ready_i);
    assign cap_d = cap_q | eng_yumi_o;
    assign ser_start = state_q == WAIT && (cap_d & active) == active;
    assign eng_iters_o = iters_q;
    assign eng_slen_o = slen_q + SLEN_W'(4);
    assign eng_pass_o = pass_q;

    for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_eng
        logic [SALT_MAX-1:0] s;
        assign active[e] = CW'(e) < rem;
        assign s = insert_blk_idx(SALT_MAX'(salt_q) << (SALT_MAX - SALT_W), slen_q, 32'(base_q) + 32'(e + 1));
        assign eng_salt_o[e*SALT_W +: SALT_W] = s[SALT_MAX-1 -: SALT_W];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            iters_q <= '0;
            slen_q  <= '0;
            nblk_q  <= '0;
            base_q  <= '0;
            pass_q  <= '0;
            salt_q  <= '0;
            sent_q  <= '0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                LOAD: if (v_i) begin
                    wcnt_q <= (wcnt_q == LOAD_END) ? '0 : wcnt_q + LW'(1);
                    if (wcnt_q == '0) begin
                        iters_q <= data_i[ITERS_LSB +: 32];
                        slen_q  <= data_i[BLK_W +: SLEN_W];
                        nblk_q  <= nblk_d;
                    end else if (wcnt_q <= PASS_END) pass_q <= PASS_W'({pass_q, data_i});
                    else salt_q <= SALT_W'({salt_q, data_i});
                    if (wcnt_q == LOAD_END) begin
                        state_q <= DISPATCH;
                        base_q  <= '0;
                        sent_q  <= '0;
                    end
                end
                DISPATCH: begin
                    sent_q <= sent_d;
                    if ((sent_d & active) == active) begin
                        state_q <= WAIT;
                        cap_q   <= '0;
                    end
                end
                WAIT: begin
                    cap_q <= cap_d;
                    if (ser_start) state_q <= DRAIN;
                end
                default: if (ser_done) begin
                    base_q  <= next_base;
                    sent_q  <= '0;
                    state_q <= last_round ? LOAD : DISPATCH;
                end
            endcase
        end
    end

    kda_sched_ser #(.DATA_W(DATA_W), .NUM_ENGINES(NUM_ENGINES), .HASH_W(HASH_W)) u_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_i    (eng_yumi_o),
        .hash_i  (eng_hash_i),
        .start_i (ser_start),
        .slots_i (slots),
        .data_o  (data_o),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .done_o  (ser_done)
    );

`ifdef KDA_SCHED_PERF_EN
    logic [31:0] perf_q;
    logic perf_run_q, w0_acc;
    assign w0_acc = ready_o && v_i && wcnt_q == '0;
    assign perf_cycles_o = perf_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_q     <= '0;
            perf_run_q <= 1'b0;
        end else if (w0_acc) begin
            perf_q     <= '0;
            perf_run_q <= 1'b1;
        end else if (perf_run_q) begin
            perf_q <= (perf_q == '1) ? perf_q : perf_q + 32'd1;
            if (ser_done && last_round) perf_run_q <= 1'b0;
        end
    end
`endif
endmodule
